data_ram_responder: RTL

DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

---
 rtl/data_ram_responder_pkg.sv | 19 +
 rtl/data_ram_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the CPU data-memory responder: FSM encoding and
// default acknowledge timeout.
package data_ram_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10,
    StErr  = 2'b11
  } ram_state_e;

  localparam int unsigned DefAckTimeout = 255;
  localparam int unsigned CntWidth      = 16;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/data_ram_responder.sv
// Bridges single-cycle CPU load/store requests to a handshaked backing memory,
// stalling the pipeline until mem_ack, a timeout, or an alignment fault.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = DefAckTimeout,
  parameter bit          ADDR_CHECK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ram_cs,
  input  logic        ram_ren,
  input  logic        ram_wen,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_din,
  output logic [31:0] ram_dout,
  output logic        ram_stall,
  output logic        bus_err,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CntWidth-1:0] TimeoutCnt = CntWidth'(ACK_TIMEOUT);

  ram_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] cnt_inc;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         ram_dout_q, ram_dout_d;
  logic                bus_err_q, bus_err_d;

  logic access_start;
  logic misaligned;

  assign access_start = ram_cs & (ram_ren | ram_wen);
  assign misaligned   = ADDR_CHECK && (ram_addr[1:0] != 2'b00);
  assign cnt_inc      = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ram_dout_d  = ram_dout_q;
    bus_err_d   = 1'b0;
    ram_stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access_start) begin
          ram_stall = 1'b1;
          if (misaligned) begin
            state_d   = StErr;
            bus_err_d = 1'b1;
            // A faulting store leaves the last load result intact.
            if (!ram_wen) begin
              ram_dout_d = '0;
            end
          end else begin
            state_d     = StBusy;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = ram_wen;
            mem_addr_d  = word_addr(ram_addr);
            mem_wdata_d = ram_din;
          end
        end
      end

      StBusy: begin
        ram_stall = 1'b1;
        // An ack arriving in the timeout cycle still completes the access.
        if (mem_ack) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            ram_dout_d = mem_rdata;
          end
        end else if (cnt_inc == TimeoutCnt) begin
          state_d   = StErr;
          cnt_d     = cnt_inc;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!mem_we_q) begin
            ram_dout_d = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      StErr: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ram_dout_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ram_dout_q  <= ram_dout_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ram_dout  = ram_dout_q;
  assign bus_err   = bus_err_q;

endmodule
